// File: rtl/motor_pwm_array_pkg.sv
// rtl/motor_pwm_array_pkg.sv - mode encodings and channel state type for the H-bridge PWM array
package motor_pkg;

  localparam logic [1:0] CTL_COAST = 2'b00;
  localparam logic [1:0] CTL_FWD   = 2'b01;
  localparam logic [1:0] CTL_REV   = 2'b10;
  localparam logic [1:0] CTL_BRAKE = 2'b11;

  // Driven states share their numeric value with the ctl code; DEAD sits above them.
  typedef enum logic [2:0] {
    ST_COAST = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_BRAKE = 3'd3,
    ST_DEAD  = 3'd4
  } ch_state_e;

  function automatic ch_state_e ctl_to_state(input logic [1:0] ctl);
    case (ctl)
      CTL_FWD:   return ST_FWD;
      CTL_REV:   return ST_REV;
      CTL_BRAKE: return ST_BRAKE;
      default:   return ST_COAST;
    endcase
  endfunction

endpackage

// File: rtl/motor_pwm_array_if.sv
// rtl/motor_pwm_array_if.sv - CPU-side control and driver-side bridge signals of the PWM array
interface motor_pwm_array_if #(
  parameter int NUM_CH = 4,
  parameter int PWM_W  = 8
);
  logic                      en;
  logic [2*NUM_CH-1:0]       ctl;
  logic [PWM_W*NUM_CH-1:0]   vel;
  logic [2*NUM_CH-1:0]       out;
  logic [NUM_CH-1:0]         dead;
  logic                      period_start;

  modport master (output en, ctl, vel, input out, dead, period_start);
  modport slave  (input en, ctl, vel, output out, dead, period_start);
endinterface

// File: rtl/motor_pwm_channel.sv
// rtl/motor_pwm_channel.sv - one H-bridge channel: shadow regs, mode FSM with dead time, PWM compare
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int DEADTIME = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic [1:0]       ctl_i,
  input  logic [PWM_W-1:0] vel_i,
  output logic [1:0]       out_o,
  output logic             dead_o
);

  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [PWM_W-1:0] VMAX = '1;
  localparam logic [DW-1:0]    DT   = DW'(DEADTIME);

  logic [PWM_W-1:0] vel_sh_q, vel_sh_d;
  logic [1:0]       ctl_sh_q, ctl_sh_d;
  ch_state_e        state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [1:0]       out_q, out_d;
  logic             dead_q, dead_d;
  ch_state_e        tgt;
  logic             pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel_sh_q <= '0;
      ctl_sh_q <= CTL_COAST;
      state_q  <= ST_COAST;
      dcnt_q   <= '0;
      out_q    <= 2'b00;
      dead_q   <= 1'b0;
    end else begin
      vel_sh_q <= vel_sh_d;
      ctl_sh_q <= ctl_sh_d;
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      out_q    <= out_d;
      dead_q   <= dead_d;
    end
  end

  always_comb begin
    vel_sh_d = load_i ? vel_i : vel_sh_q;
    ctl_sh_d = load_i ? ctl_i : ctl_sh_q;
    tgt      = ctl_to_state(ctl_sh_q);
    pwm      = (vel_sh_q == VMAX) || (cnt_i < vel_sh_q);
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    out_d    = 2'b00;
    dead_d   = 1'b0;

    case (state_q)
      ST_FWD:   out_d = {1'b0, pwm};
      ST_REV:   out_d = {pwm, 1'b0};
      ST_BRAKE: out_d = 2'b11;
      ST_DEAD:  dead_d = 1'b1;
      default:  out_d = 2'b00;
    endcase

    if (!en_i) begin
      state_d = ST_COAST;
      dcnt_d  = '0;
      out_d   = 2'b00;
      dead_d  = 1'b0;
    end else if (state_q == ST_DEAD) begin
      if (tgt == ST_COAST) begin
        state_d = ST_COAST;
        dcnt_d  = '0;
      end else begin
        // Leaving on the count of 1 keeps the channel in DEAD for exactly DEADTIME clocks.
        dcnt_d = dcnt_q - DW'(1);
        if (dcnt_q <= DW'(1)) state_d = tgt;
      end
    end else if (tgt != state_q) begin
      if (tgt == ST_COAST || state_q == ST_COAST || DEADTIME == 0) begin
        state_d = tgt;
      end else begin
        state_d = ST_DEAD;
        dcnt_d  = DT;
      end
    end
  end

  assign out_o  = out_q;
  assign dead_o = dead_q;

endmodule

// File: rtl/motor_pwm_array.sv
// rtl/motor_pwm_array.sv - multi-channel H-bridge PWM driver with shared period counter
module motor_pwm_array
  import motor_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PWM_W    = 8,
  parameter int DEADTIME = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  motor_pwm_array_if.slave  bus
);

  logic [PWM_W-1:0]  cnt_q, cnt_d;
  logic              ps_q, ps_d;
  logic              load;
  logic [2*NUM_CH-1:0] out_w;
  logic [NUM_CH-1:0]   dead_w;

  // Shadows load on the last count so the new values govern the period from cnt==0.
  always_comb begin
    load  = (cnt_q == {PWM_W{1'b1}});
    cnt_d = cnt_q + 1'b1;
    ps_d  = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motor_pwm_channel #(
      .PWM_W    (PWM_W),
      .DEADTIME (DEADTIME)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (bus.en),
      .load_i (load),
      .cnt_i  (cnt_q),
      .ctl_i  (bus.ctl[2*i +: 2]),
      .vel_i  (bus.vel[PWM_W*i +: PWM_W]),
      .out_o  (out_w[2*i +: 2]),
      .dead_o (dead_w[i])
    );
  end

  assign bus.out          = out_w;
  assign bus.dead         = dead_w;
  assign bus.period_start = ps_q;

endmodule
